timer_scheduler: RTL and testbench

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler.sv | 112 +++++++++++
 tb/tb_timer_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - round-robin arbiter sharing one hardware timer among 4 requesters
module timer_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_dur,
  output logic [3:0]  ack,
  output logic        err,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        tmr_start,
  output logic [7:0]  tmr_duration,
  input  logic        tmr_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;

  state_t      state, state_n;
  logic [1:0]  last, last_n, gid_n, pick, idx;
  logic        found;
  logic [7:0]  dur_n, pick_dur;
  logic [8:0]  wd, wd_n;
  logic        start_n, err_n;
  logic [3:0]  ack_n;

  assign busy = (state != IDLE);

  // Search last+1, last+2, last+3, last; the 4th step wraps back to last itself.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    pick_dur = req_dur[{pick, 3'b000} +: 8];
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    gid_n   = grant_id;
    dur_n   = tmr_duration;
    wd_n    = wd;
    start_n = 1'b0;
    ack_n   = 4'b0000;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gid_n  = pick;
          last_n = pick;
          dur_n  = pick_dur;
          wd_n   = 9'd0;
          if (pick_dur != 8'd0) begin
            state_n = RUN;
            start_n = 1'b1;
          end else begin
            // A zero-length timer never raises done, so complete immediately.
            state_n = DONE;
            ack_n   = 4'b0001 << pick;
          end
        end
      end
      RUN: begin
        if (tmr_done) begin
          state_n = DONE;
          ack_n   = 4'b0001 << grant_id;
        end else if (wd == ({1'b0, tmr_duration} + 9'd3)) begin
          state_n = DONE;
          ack_n   = 4'b0001 << grant_id;
          err_n   = 1'b1;
        end else if (!req[grant_id]) begin
          state_n = GAP;
        end else begin
          start_n = 1'b1;
          wd_n    = wd + 9'd1;
        end
      end
      DONE:    state_n = GAP;
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= 2'd3;
      grant_id     <= 2'd0;
      tmr_duration <= 8'd0;
      wd           <= 9'd0;
      tmr_start    <= 1'b0;
      ack          <= 4'b0000;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      last         <= last_n;
      grant_id     <= gid_n;
      tmr_duration <= dur_n;
      wd           <= wd_n;
      tmr_start    <= start_n;
      ack          <= ack_n;
      err          <= err_n;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - vector table plus scoreboard bench for timer_scheduler
module tb_timer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_dur;
  logic [3:0]  ack;
  logic        err, busy, tmr_start, tmr_done;
  logic [1:0]  grant_id;
  logic [7:0]  tmr_duration;
  bit          timer_en;
  int          tcnt;

  timer_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dur(req_dur), .ack(ack), .err(err),
    .busy(busy), .grant_id(grant_id), .tmr_start(tmr_start),
    .tmr_duration(tmr_duration), .tmr_done(tmr_done)
  );

  always #5 clk = ~clk;

  // Timer model: done appears in the (D+1)th cycle of tmr_start being high.
  always @(posedge clk) begin
    if (!tmr_start) tcnt <= 0;
    else            tcnt <= tcnt + 1;
  end
  assign tmr_done = tmr_start && timer_en && (tcnt == int'(tmr_duration));

  typedef struct {
    int         gid;
    logic [3:0] ack;
    bit         err;
    int         ack_k;
    int         start;
    int         idle;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] d;
    bit         ten;
    int         cancel;
    logic [3:0] eack;
    bit         eerr;
    int         eack_k;
    int         estart;
    int         eidle;
  } vec_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: cycle 1 is the first cycle after the grant edge.
  bit         m_prev = 1'b0;
  int         m_k, m_gid, m_ack_k, m_start;
  logic [3:0] m_ack;
  bit         m_err, m_orphan;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_prev = 1'b0;
      m_k    = 0;
    end else begin
      if (busy && !m_prev) begin
        m_k = 1; m_gid = int'(grant_id); m_ack = 4'b0; m_ack_k = 0;
        m_err = 1'b0; m_start = 0; m_orphan = 1'b0;
      end else if (busy) begin
        m_k++;
      end
      if (busy) begin
        if (ack != 4'b0) begin
          m_ack = ack; m_ack_k = m_k; m_err = err;
        end
        if (err && ack == 4'b0) m_orphan = 1'b1;
        m_start += int'(tmr_start);
      end
      if (!busy && m_prev) begin
        if (sbq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_txn actual=gid%0d required=none", m_gid);
        end else begin
          e = sbq.pop_front();
          chk("grant_id", m_gid, e.gid);
          chk("ack", int'(m_ack), int'(e.ack));
          chk("ack_cycle", m_ack_k, e.ack_k);
          chk("err", int'(m_err), int'(e.err));
          chk("err_orphan", int'(m_orphan), 0);
          chk("start_cycles", m_start, e.start);
          chk("idle_cycle", m_k + 1, e.idle);
        end
      end
      m_prev = busy;
    end
  end

  task automatic run_seq(input logic [3:0] r, input logic [31:0] rd, input bit ten,
                         input int cancel_id, input int cancel_k, input int rearm_in,
                         input bit scramble);
    int k = 0;
    int n;
    int rearm = rearm_in;
    bit started = 1'b0;
    bit prev = 1'b0;
    logic [3:0] pend = 4'b0;
    timer_en = ten;
    req_dur  = rd;
    req      = r;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      req  = req | pend;
      pend = 4'b0;
      if (busy && !prev) begin
        k = 1;
        if (!started && scramble) req_dur = ~req_dur;
        started = 1'b1;
      end else if (busy) begin
        k++;
      end
      prev = busy;
      if (cancel_k > 0 && k == cancel_k) req[cancel_id] = 1'b0;
      if (ack != 4'b0) begin
        req = req & ~ack;
        if (rearm > 0) begin
          pend = ack;
          rearm--;
        end
      end
      if (started && !busy && sbq.size() == 0 && (req | pend) == 4'b0) break;
    end
    if (n >= 1000) begin
      nvec++; nerr++;
      $display("FAIL seq_bound actual=expired required=complete");
    end
    req = 4'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] rd;
    exp_t e;
    vecs[0] = '{0, 8'd5,   1'b1, 0, 4'b0001, 1'b0, 7,   6,   9};
    vecs[1] = '{2, 8'd0,   1'b1, 0, 4'b0100, 1'b0, 1,   0,   3};
    vecs[2] = '{1, 8'd4,   1'b0, 0, 4'b0010, 1'b1, 9,   8,   11};
    vecs[3] = '{3, 8'd10,  1'b1, 4, 4'b0000, 1'b0, 0,   4,   6};
    vecs[4] = '{0, 8'd1,   1'b1, 0, 4'b0001, 1'b0, 3,   2,   5};
    vecs[5] = '{3, 8'd255, 1'b1, 0, 4'b1000, 1'b0, 257, 256, 259};
    vecs[6] = '{1, 8'd255, 1'b0, 0, 4'b0010, 1'b1, 260, 259, 262};
    vecs[7] = '{2, 8'd3,   1'b1, 2, 4'b0000, 1'b0, 0,   2,   4};
    vecs[8] = '{0, 8'd2,   1'b1, 3, 4'b0001, 1'b0, 4,   3,   6};
    vecs[9] = '{2, 8'd1,   1'b0, 5, 4'b0100, 1'b1, 6,   5,   8};

    rst_n = 1'b0; req = 4'b0; req_dur = 32'hFFFF_FFFF; timer_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_tmr_start", int'(tmr_start), 0);
    chk("rst_tmr_duration", int'(tmr_duration), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four requesting, duration 2 each; requester 0 comes back once.
    for (int i = 0; i < 5; i++) begin
      e = '{i % 4, 4'b0001 << (i % 4), 1'b0, 4, 3, 6};
      sbq.push_back(e);
    end
    run_seq(4'hF, 32'h0202_0202, 1'b1, 0, 0, 1, 1'b0);

    foreach (vecs[i]) begin
      rd = $urandom;
      rd[8*vecs[i].id +: 8] = vecs[i].d;
      e = '{vecs[i].id, vecs[i].eack, vecs[i].eerr, vecs[i].eack_k, vecs[i].estart, vecs[i].eidle};
      sbq.push_back(e);
      run_seq(4'b0001 << vecs[i].id, rd, vecs[i].ten, vecs[i].id, vecs[i].cancel, 0, 1'b1);
    end

    // Reset in the middle of a run, then confirm requester 0 regains first priority.
    req = 4'b0001; req_dur = 32'h0000_000A; timer_en = 1'b1;
    for (int n = 0; n < 10 && !busy; n++) @(negedge clk);
    chk("midrun_busy_before", int'(busy), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_tmr_start", int'(tmr_start), 0);
    chk("midrun_busy", int'(busy), 0);
    chk("midrun_ack", int'(ack), 0);
    chk("midrun_tmr_duration", int'(tmr_duration), 0);
    req = 4'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sbq.push_back('{0, 4'b0001, 1'b0, 3, 2, 5});
    sbq.push_back('{1, 4'b0010, 1'b0, 3, 2, 5});
    run_seq(4'b0011, 32'h0000_0101, 1'b1, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
